// File: rtl/morse_quiz_pkg.sv
// morse_quiz_pkg
// Shared types and constants for the Morse quiz controller:
//   state_t        FSM state encoding (also driven out on the debug port)
//   SYM_*          2-bit decoder symbol codes
//   NUM_LETTERS    size of the target alphabet (A..Z)
//   morse_pattern  letter index -> 10-bit pattern, symbol one in [9:8]
package morse_quiz_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PRESENT    = 3'd1,
      ST_WAIT_INPUT = 3'd2,
      ST_CHECK      = 3'd3,
      ST_FEEDBACK   = 3'd4,
      ST_DONE       = 3'd5
   } state_t;

   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;

   localparam int NUM_LETTERS = 26;

   // Unused trailing fields are SYM_NONE so a compare needs all five to agree.
   function automatic logic [9:0] morse_pattern(input logic [4:0] letter);
      case (letter)
         5'd0:    morse_pattern = {SYM_DOT,  SYM_DASH, SYM_NONE, SYM_NONE, SYM_NONE}; // A
         5'd1:    morse_pattern = {SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_NONE}; // B
         5'd2:    morse_pattern = {SYM_DASH, SYM_DOT,  SYM_DASH, SYM_DOT,  SYM_NONE}; // C
         5'd3:    morse_pattern = {SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_NONE, SYM_NONE}; // D
         5'd4:    morse_pattern = {SYM_DOT,  SYM_NONE, SYM_NONE, SYM_NONE, SYM_NONE}; // E
         5'd5:    morse_pattern = {SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_DOT,  SYM_NONE}; // F
         5'd6:    morse_pattern = {SYM_DASH, SYM_DASH, SYM_DOT,  SYM_NONE, SYM_NONE}; // G
         5'd7:    morse_pattern = {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_NONE}; // H
         5'd8:    morse_pattern = {SYM_DOT,  SYM_DOT,  SYM_NONE, SYM_NONE, SYM_NONE}; // I
         5'd9:    morse_pattern = {SYM_DOT,  SYM_DASH, SYM_DASH, SYM_DASH, SYM_NONE}; // J
         5'd10:   morse_pattern = {SYM_DASH, SYM_DOT,  SYM_DASH, SYM_NONE, SYM_NONE}; // K
         5'd11:   morse_pattern = {SYM_DOT,  SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_NONE}; // L
         5'd12:   morse_pattern = {SYM_DASH, SYM_DASH, SYM_NONE, SYM_NONE, SYM_NONE}; // M
         5'd13:   morse_pattern = {SYM_DASH, SYM_DOT,  SYM_NONE, SYM_NONE, SYM_NONE}; // N
         5'd14:   morse_pattern = {SYM_DASH, SYM_DASH, SYM_DASH, SYM_NONE, SYM_NONE}; // O
         5'd15:   morse_pattern = {SYM_DOT,  SYM_DASH, SYM_DASH, SYM_DOT,  SYM_NONE}; // P
         5'd16:   morse_pattern = {SYM_DASH, SYM_DASH, SYM_DOT,  SYM_DASH, SYM_NONE}; // Q
         5'd17:   morse_pattern = {SYM_DOT,  SYM_DASH, SYM_DOT,  SYM_NONE, SYM_NONE}; // R
         5'd18:   morse_pattern = {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_NONE, SYM_NONE}; // S
         5'd19:   morse_pattern = {SYM_DASH, SYM_NONE, SYM_NONE, SYM_NONE, SYM_NONE}; // T
         5'd20:   morse_pattern = {SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_NONE, SYM_NONE}; // U
         5'd21:   morse_pattern = {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_NONE}; // V
         5'd22:   morse_pattern = {SYM_DOT,  SYM_DASH, SYM_DASH, SYM_NONE, SYM_NONE}; // W
         5'd23:   morse_pattern = {SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_NONE}; // X
         5'd24:   morse_pattern = {SYM_DASH, SYM_DOT,  SYM_DASH, SYM_DASH, SYM_NONE}; // Y
         5'd25:   morse_pattern = {SYM_DASH, SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_NONE}; // Z
         default: morse_pattern = '0;
      endcase
   endfunction

endpackage

// File: rtl/morse_quiz_controller_lfsr.sv
// morse_lfsr8
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) plus a mod-26
// reduction of its current value into a letter index.
//   clock   in   system clock
//   reset   in   synchronous active-low reset, reloads LFSR_SEED
//   letter  out  current LFSR value mod 26 (0=A..25=Z)
module morse_lfsr8
   import morse_quiz_pkg::*;
#(
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   output logic [4:0] letter
);

   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] r1, r2, r3;

   // Maximal-length taps; a non-zero seed never reaches the all-zero state.
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Binary-weighted subtract-26 reduction: 208, 104, 52, 26 covers 0..255.
   always_comb begin
      r1 = (lfsr_q >= 8'(NUM_LETTERS * 8)) ? lfsr_q - 8'(NUM_LETTERS * 8) : lfsr_q;
      r2 = (r1 >= 8'(NUM_LETTERS * 4)) ? r1 - 8'(NUM_LETTERS * 4) : r1;
      r3 = (r2 >= 8'(NUM_LETTERS * 2)) ? r2 - 8'(NUM_LETTERS * 2) : r2;
      letter = 5'((r3 >= 8'(NUM_LETTERS)) ? r3 - 8'(NUM_LETTERS) : r3);
   end

   always_ff @(posedge clock) begin
      if (!reset) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/morse_quiz_controller.sv
// morse_quiz_controller
// Runs one Morse training session: picks a target letter, waits for the
// decoder's finished letter, scores it, holds feedback, repeats for
// NUM_ROUNDS letters.
// Optional build macro: MORSE_QUIZ_RETRY_EN (one retry of a wrong answer).
// Ports:
//   clock, reset            system clock, synchronous active-low reset
//   start                   level; rising edge in IDLE/DONE starts a session
//   letter_done             decoder letter-finished level flag
//   morse_one..morse_five   decoded symbols (00 none, 01 dot, 10 dash)
//   target_letter/valid     current target and its qualifier
//   result_valid            one-cycle pulse on FEEDBACK entry
//   result_correct          match flag, held through FEEDBACK
//   timed_out               timeout flag, held through FEEDBACK
//   score, round            session score and 1-based round (0 in IDLE)
//   session_done, state     DONE indicator and raw FSM state
//
// state       | meaning
// ------------+------------------------------------------------
// IDLE        | after reset, waiting for start rise
// PRESENT     | one cycle: latch target, load timeout timer
// WAIT_INPUT  | waiting for a fresh letter_done rise or timeout
// CHECK       | one cycle: compare captured symbols, update score
// FEEDBACK    | hold result for FEEDBACK_CYCLES
// DONE        | session finished, score/round held
module morse_quiz_controller
   import morse_quiz_pkg::*;
#(
   parameter int         NUM_ROUNDS      = 10,
   parameter int         TIMEOUT_CYCLES  = 50_000_000,
   parameter int         FEEDBACK_CYCLES = 25_000_000,
   parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       letter_done,
   input  logic [1:0] morse_one,
   input  logic [1:0] morse_two,
   input  logic [1:0] morse_three,
   input  logic [1:0] morse_four,
   input  logic [1:0] morse_five,
   output logic [4:0] target_letter,
   output logic       target_valid,
   output logic       result_valid,
   output logic       result_correct,
   output logic       timed_out,
   output logic [7:0] score,
   output logic [7:0] round,
   output logic       session_done,
   output logic [2:0] state
);

`ifdef MORSE_QUIZ_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   localparam int TMR_MAX = (TIMEOUT_CYCLES > FEEDBACK_CYCLES) ? TIMEOUT_CYCLES : FEEDBACK_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] FEEDBACK_LOAD = TMR_W'(FEEDBACK_CYCLES - 1);
   localparam logic [7:0]       LAST_ROUND    = 8'(NUM_ROUNDS);

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [4:0]       target_q, target_d;
   logic [9:0]       capt_q, capt_d;
   logic [7:0]       score_q, score_d;
   logic [7:0]       round_q, round_d;
   logic             result_valid_q, result_valid_d;
   logic             result_correct_q, result_correct_d;
   logic             timed_out_q, timed_out_d;
   logic             retry_q, retry_d;
   logic             start_q, start_d, start_prev_q, start_prev_d;
   logic             ld_q, ld_d, ld_prev_q, ld_prev_d;

   logic [4:0]       lfsr_letter;
   logic             start_rise, ld_rise, tmr_zero, match;

   morse_lfsr8 #(
      .LFSR_SEED (LFSR_SEED)
   ) u_lfsr (
      .clock  (clock),
      .reset  (reset),
      .letter (lfsr_letter)
   );

   always_comb begin
      start_d      = start;
      start_prev_d = start_q;
      ld_d         = letter_done;
      ld_prev_d    = ld_q;
   end

   // Edges come from the registered copies only, so a letter_done that is
   // already high when WAIT_INPUT is entered never looks like a rise.
   assign start_rise = start_q & ~start_prev_q;
   assign ld_rise    = ld_q & ~ld_prev_q;
   assign tmr_zero   = (tmr_q == '0);
   assign match      = (capt_q == morse_pattern(target_q));

   always_comb begin
      state_d          = state_q;
      tmr_d            = tmr_q;
      target_d         = target_q;
      capt_d           = capt_q;
      score_d          = score_q;
      round_d          = round_q;
      result_valid_d   = 1'b0;
      result_correct_d = result_correct_q;
      timed_out_d      = timed_out_q;
      retry_d          = retry_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_rise) begin
               state_d = ST_PRESENT;
               score_d = '0;
               round_d = 8'd1;
               retry_d = 1'b0;
            end
         end
         ST_PRESENT: begin
            // A retry attempt keeps the previous target.
            if (!retry_q) target_d = lfsr_letter;
            tmr_d   = TIMEOUT_LOAD;
            state_d = ST_WAIT_INPUT;
         end
         ST_WAIT_INPUT: begin
            if (ld_rise) begin
               capt_d  = {morse_one, morse_two, morse_three, morse_four, morse_five};
               state_d = ST_CHECK;
            end else if (tmr_zero) begin
               result_valid_d   = 1'b1;
               result_correct_d = 1'b0;
               timed_out_d      = 1'b1;
               tmr_d            = FEEDBACK_LOAD;
               state_d          = ST_FEEDBACK;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_CHECK: begin
            result_valid_d   = 1'b1;
            result_correct_d = match;
            timed_out_d      = 1'b0;
            if (match && (score_q != 8'hFF)) score_d = score_q + 8'd1;
            tmr_d   = FEEDBACK_LOAD;
            state_d = ST_FEEDBACK;
         end
         ST_FEEDBACK: begin
            if (tmr_zero) begin
               result_correct_d = 1'b0;
               timed_out_d      = 1'b0;
               if (RETRY_EN && !retry_q && !result_correct_q && !timed_out_q) begin
                  retry_d = 1'b1;
                  state_d = ST_PRESENT;
               end else begin
                  retry_d = 1'b0;
                  if (round_q == LAST_ROUND) begin
                     state_d = ST_DONE;
                  end else begin
                     round_d = round_q + 8'd1;
                     state_d = ST_PRESENT;
                  end
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         tmr_q            <= '0;
         target_q         <= '0;
         capt_q           <= '0;
         score_q          <= '0;
         round_q          <= '0;
         result_valid_q   <= 1'b0;
         result_correct_q <= 1'b0;
         timed_out_q      <= 1'b0;
         retry_q          <= 1'b0;
         start_q          <= 1'b0;
         start_prev_q     <= 1'b0;
         ld_q             <= 1'b0;
         ld_prev_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         tmr_q            <= tmr_d;
         target_q         <= target_d;
         capt_q           <= capt_d;
         score_q          <= score_d;
         round_q          <= round_d;
         result_valid_q   <= result_valid_d;
         result_correct_q <= result_correct_d;
         timed_out_q      <= timed_out_d;
         retry_q          <= retry_d;
         start_q          <= start_d;
         start_prev_q     <= start_prev_d;
         ld_q             <= ld_d;
         ld_prev_q        <= ld_prev_d;
      end
   end

   assign state          = state_q;
   assign target_letter  = target_q;
   assign target_valid   = (state_q == ST_PRESENT) || (state_q == ST_WAIT_INPUT) ||
                           (state_q == ST_CHECK)   || (state_q == ST_FEEDBACK);
   assign result_valid   = result_valid_q;
   assign result_correct = result_correct_q;
   assign timed_out      = timed_out_q;
   assign score          = score_q;
   assign round          = round_q;
   assign session_done   = (state_q == ST_DONE);

endmodule
